// File: rtl/vga_controller.sv
`timescale 1ns/1ps
// vga_controller: 640x480@60 raster timing generator (free-running h/v counters).
// Ports: i_clk pixel clock, i_rst_n async active-low reset,
//        o_hsync/o_vsync syncs (active level SYNC_POL), o_hcount/o_vcount
//        pixel coordinate, o_de visible-pixel qualifier.
// Optional macro VGA_FRAME_STROBE_EN adds o_frame: one-cycle pulse at (0, V_ACTIVE).
module vga_controller #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
`ifdef VGA_FRAME_STROBE_EN
    output logic       o_frame,
`endif
    output logic       o_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_controller: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds: a sync end can legitimately equal 1024
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;

    logic [9:0] w_hcount_nxt;
    logic [9:0] w_vcount_nxt;
    logic [10:0] w_hx;
    logic [10:0] w_vx;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_de_nxt;

    always_comb begin
        w_hcount_nxt = r_hcount + 10'd1;
        w_vcount_nxt = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = 10'd0;
            w_vcount_nxt = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
    end

    // Decode from the next counter values so syncs/de line up with the counts
    always_comb begin
        w_hx     = {1'b0, w_hcount_nxt};
        w_vx     = {1'b0, w_vcount_nxt};
        w_hs_act = (w_hx >= HS_START) && (w_hx < HS_END);
        w_vs_act = (w_vx >= VS_START) && (w_vx < VS_END);
        w_de_nxt = (w_hx < H_VIS) && (w_vx < V_VIS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_de     <= 1'b0;
        end else begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_de     <= w_de_nxt;
        end
    end

`ifdef VGA_FRAME_STROBE_EN
    logic r_frame;
    logic w_frame_nxt;

    // Start of vertical blanking: first pixel of line V_ACTIVE
    always_comb begin
        w_frame_nxt = (w_hcount_nxt == 10'd0) && (w_vx == V_VIS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_frame_nxt;
        end
    end

    assign o_frame = r_frame;
`endif

    assign o_hcount = r_hcount;
    assign o_vcount = r_vcount;
    assign o_hsync  = r_hsync;
    assign o_vsync  = r_vsync;
    assign o_de     = r_de;

endmodule

// File: tb/tb_vga_controller.sv
`timescale 1ns/1ps
// tb_vga_controller: checks a default 640x480 instance and a tiny
// SYNC_POL=1 instance against a position-from-elapsed-clocks model.
module tb_vga_controller;

    localparam int M_HA = 640, M_HF = 16, M_HS = 96, M_HB = 48;
    localparam int M_VA = 480, M_VF = 10, M_VS = 2,  M_VB = 33;
    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de;
    logic [9:0] a_h, a_v;
    logic       b_hs, b_vs, b_de;
    logic [9:0] b_h, b_v;
`ifdef VGA_FRAME_STROBE_EN
    logic       a_fr, b_fr;
`endif

    vga_controller u_main (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .o_hsync  (a_hs),
        .o_vsync  (a_vs),
        .o_hcount (a_h),
        .o_vcount (a_v),
`ifdef VGA_FRAME_STROBE_EN
        .o_frame  (a_fr),
`endif
        .o_de     (a_de)
    );

    vga_controller #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .SYNC_POL (1'b1)
    ) u_small (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .o_hsync  (b_hs),
        .o_vsync  (b_vs),
        .o_hcount (b_h),
        .o_vcount (b_v),
`ifdef VGA_FRAME_STROBE_EN
        .o_frame  (b_fr),
`endif
        .o_de     (b_de)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;
    int b_prev = 0;
    int b_vs_cnt = 0;
    int hs_cnt = 0;
    int de_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Position is simply elapsed clocks since reset release, modulo frame
    function automatic logic [31:0] model(
        input int tt, input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input logic pol);
        int ht, vt, pos, h, v;
        logic hsa, vsa, de;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        pos = tt % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        hsa = (h >= ha + hf) && (h < ha + hf + hs);
        vsa = (v >= va + vf) && (v < va + vf + vs);
        de  = (h < ha) && (v < va);
        return {9'd0, 10'(h), 10'(v), hsa ? pol : ~pol, vsa ? pol : ~pol, de};
    endfunction

    function automatic logic exp_frame(input int tt, input int ht,
                                       input int vt, input int va);
        int pos;
        pos = tt % (ht * vt);
        return (pos == va * ht);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_main"}, {9'd0, a_h, a_v, a_hs, a_vs, a_de},
            {9'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
        chk({tag, "_small"}, {9'd0, b_h, b_v, b_hs, b_vs, b_de},
            {9'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0});
`ifdef VGA_FRAME_STROBE_EN
        chk({tag, "_frame"}, {30'd0, a_fr, b_fr}, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        @(negedge clk);
        chk("main", {9'd0, a_h, a_v, a_hs, a_vs, a_de},
            model(t, M_HA, M_HF, M_HS, M_HB, M_VA, M_VF, M_VS, M_VB, 1'b0));
        chk("small", {9'd0, b_h, b_v, b_hs, b_vs, b_de},
            model(t, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1));
`ifdef VGA_FRAME_STROBE_EN
        chk("main_frame", {31'd0, a_fr},
            {31'd0, exp_frame(t, M_HA + M_HF + M_HS + M_HB,
                              M_VA + M_VF + M_VS + M_VB, M_VA)});
        chk("small_frame", {31'd0, b_fr},
            {31'd0, exp_frame(t, S_HT, S_VT, S_VA)});
`endif
        if (b_vs == 1'b1) b_vs_cnt++;
        if (b_h == 10'd0 && b_v == 10'd0) begin
            chk("small_frame_period", 32'(t - b_prev), 32'(S_HT * S_VT));
            chk("small_vsync_len", 32'(b_vs_cnt), 32'(S_VS * S_HT));
            b_prev   = t;
            b_vs_cnt = 0;
        end
        if (t <= M_HA + M_HF + M_HS + M_HB) begin
            if (a_hs == 1'b0) hs_cnt++;
            if (a_de) de_cnt++;
        end
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        t        = 0;
        b_prev   = 0;
        b_vs_cnt = 0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_reset("reset_hold");
        end
        release_reset();

        repeat (M_HA + M_HF + M_HS + M_HB) step();
        chk("line_hsync_len", 32'(hs_cnt), 32'(M_HS));
        chk("line_de_len", 32'(de_cnt), 32'(M_HA));

        n = int'($urandom_range(20000, 30000));
        repeat (n) step();

        // Asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk_reset("reset_mid");
        end
        release_reset();

        n = int'($urandom_range(15000, 25000));
        repeat (n) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
